// File: rtl/y_signature_compactor.sv
// Compacts the 867-bit response bus into a 32-bit MISR signature over a
// programmed number of valid samples, controlled by a start/done handshake.
module y_signature_compactor #(
  parameter int               IN_W  = 867,
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [IN_W-1:0]  y_in,
  input  logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] sample_count
);

  localparam int NUM_WORDS = (IN_W + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         target, target_next;
  logic [CNT_W-1:0]         count_next;
  logic [CNT_W-1:0]         count_inc;
  logic [SIG_W-1:0]         sig_next;
  logic [SIG_W-1:0]         fold;
  logic [SIG_W-1:0]         misr;
  logic [NUM_WORDS*SIG_W-1:0] y_ext;

  // Bits i and i+32 alias onto the same fold bit; that loss is accepted.
  always_comb begin
    y_ext = '0;
    y_ext[IN_W-1:0] = y_in;
    fold = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      fold = fold ^ y_ext[k*SIG_W +: SIG_W];
    end
  end

  assign misr = {signature[SIG_W-2:0], 1'b0}
              ^ (signature[SIG_W-1] ? POLY : '0)
              ^ fold;

  assign count_inc = sample_count + CNT_W'(1);

  always_comb begin
    state_next  = state;
    sig_next    = signature;
    count_next  = sample_count;
    target_next = target;
    case (state)
      IDLE, DONE: begin
        // A sample arriving alongside start belongs to no run and is dropped.
        if (start) begin
          sig_next    = SEED;
          count_next  = '0;
          target_next = num_cycles;
          state_next  = (num_cycles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (y_valid) begin
          sig_next   = misr;
          count_next = count_inc;
          if (count_inc == target) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      signature    <= SEED;
      sample_count <= '0;
      target       <= '0;
    end else begin
      state        <= state_next;
      signature    <= sig_next;
      sample_count <= count_next;
      target       <= target_next;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_y_signature_compactor.sv
// Scoreboard bench for y_signature_compactor: expected results are queued at
// run start and popped by a monitor each time done rises.
module tb_y_signature_compactor;

  localparam int IN_W  = 867;
  localparam int SIG_W = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_cycles;
  logic [IN_W-1:0]  y_in;
  logic             y_valid;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] sample_count;

  typedef struct {
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic prev_done = 1'b0;

  y_signature_compactor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_cycles   (num_cycles),
    .y_in         (y_in),
    .y_valid      (y_valid),
    .busy         (busy),
    .done         (done),
    .signature    (signature),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: compare against the scoreboard whenever a run completes.
  always @(negedge clk) begin
    if (rst_n && done && !prev_done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("final signature", signature, e.sig);
        checkOutput("final count", 32'(sample_count), 32'(e.cnt));
        checkOutput("busy at done", 32'(busy), 32'd0);
      end
    end
    prev_done = done;
  end

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start a run and feed n back-to-back valid samples of value y.
  task automatic applyStimulus(input logic [IN_W-1:0] y, input logic [CNT_W-1:0] n,
                               input logic [SIG_W-1:0] exp_sig);
    exp_t e;
    e.sig = exp_sig;
    e.cnt = n;
    exp_q.push_back(e);
    @(negedge clk);
    start      = 1'b1;
    num_cycles = n;
    y_in       = y;
    y_valid    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n != '0) begin
      checkOutput("busy after start", 32'(busy), 32'd1);
      checkOutput("done drops on start", 32'(done), 32'd0);
      checkOutput("start sample dropped", 32'(sample_count), 32'd0);
      repeat (int'(n) - 1) @(negedge clk);
    end else begin
      checkOutput("busy never for zero", 32'(busy), 32'd0);
    end
    @(negedge clk);
    y_valid = 1'b0;
    y_in    = '0;
  endtask

  initial begin
    logic [IN_W-1:0] v;
    logic [SIG_W-1:0] held;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_cycles = '0;
    y_in       = '0;
    y_valid    = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset signature", signature, 32'hFFFFFFFF);
    checkOutput("reset count", 32'(sample_count), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;

    applyStimulus('0, 16'd1, 32'hFB3EE249);
    v = '0; v[0] = 1'b1;
    applyStimulus(v, 16'd1, 32'hFB3EE248);
    v = '0; v[32] = 1'b1;
    applyStimulus(v, 16'd1, 32'hFB3EE248);
    v = '0; v[866] = 1'b1;
    applyStimulus(v, 16'd1, 32'hFB3EE24D);

    resetDut();
    applyStimulus('0, 16'd0, 32'hFFFFFFFF);
    @(negedge clk);
    checkOutput("zero run busy", 32'(busy), 32'd0);

    // Gapped run with a start pulse that must be ignored while busy.
    resetDut();
    exp_q.push_back('{sig: 32'hE1B8AFFD, cnt: 16'd3});
    start = 1'b1; num_cycles = 16'd3; y_in = '0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("gap busy", 32'(busy), 32'd1);
    y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0; start = 1'b1; num_cycles = 16'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("gap count held", 32'(sample_count), 32'd1);
    y_valid = 1'b1;
    @(negedge clk);
    checkOutput("gap not done early", 32'(done), 32'd0);
    checkOutput("gap count two", 32'(sample_count), 32'd2);
    @(negedge clk);
    y_valid = 1'b0;
    @(negedge clk);

    // Asynchronous abort partway through a 5-sample run.
    start = 1'b1; num_cycles = 16'd5; y_in = '0;
    @(negedge clk);
    start = 1'b0; y_valid = 1'b1;
    repeat (2) @(negedge clk);
    y_valid = 1'b0;
    checkOutput("abort pre count", 32'(sample_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort signature", signature, 32'hFFFFFFFF);
    checkOutput("abort count", 32'(sample_count), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus('0, 16'd1, 32'hFB3EE249);

    // DONE must ignore traffic on y.
    @(negedge clk);
    held = signature;
    for (int i = 0; i < 10; i++) begin
      y_in    = {27{i[0] ? 32'hA5A5A5A5 : 32'h5A5A5A5A}};
      y_valid = i[0];
      @(negedge clk);
    end
    y_valid = 1'b0;
    checkOutput("done held signature", signature, 32'hFB3EE249);
    checkOutput("done held flag", 32'(done), 32'd1);
    applyStimulus('0, 16'd1, 32'hFB3EE249);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    if (held == 32'h0) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
